lsu_mem_port: RTL and testbench

Load/store unit sitting directly downstream of the RISC-V core's execute stage and upstream of data RAM. Accepts one decoded LOAD/STORE request at a time, generates word address, byte lanes and replicated store data, waits for RAM acknowledge, then returns the sign- or zero-extended load result. Owns all byte-lane and alignment logic so the core only supplies address, funct3 and store data.

---
 rtl/lsu_mem_port_if.sv | 83 ++++++++
 rtl/lsu_mem_port.sv | 238 +++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_port_if
//
// Purpose: bundles the two buses seen by the load/store unit, the
// request/response handshake towards the core's execute stage and the word
// oriented data RAM port.
//
// Signal summary:
//   req_valid / req_ready        request handshake, transfer when both high
//   req_store                    1 = STORE, 0 = LOAD
//   req_funct3 [2:0]             RV32I width code
//   req_addr [31:0]              effective byte address
//   req_wdata [31:0]             store data (rs2)
//   resp_valid                   one-cycle completion pulse
//   resp_rdata [31:0]            extended load data (0 for stores/errors)
//   resp_err                     qualifies resp_valid
//   DATA_ADDR [31:0]             RAM word address
//   DATA_OUT [31:0]              RAM write data, lane-replicated
//   BYTE_ENABLE [3:0]            active byte lanes
//   WRITE_ENABLE / READ_ENABLE   RAM strobes
//   DATA_IN [31:0]               RAM read data, valid with mem_ack
//   mem_ack                      RAM completion
//
// Modports:
//   slave  - the load/store unit's view (serves the core, drives the RAM)
//   master - the environment's view (core plus RAM)
// ---------------------------------------------------------------------------
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] DATA_ADDR;
    logic [31:0] DATA_OUT;
    logic [3:0]  BYTE_ENABLE;
    logic        WRITE_ENABLE;
    logic        READ_ENABLE;
    logic [31:0] DATA_IN;
    logic        mem_ack;

    modport slave (
        input  req_valid,
        input  req_store,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  DATA_IN,
        input  mem_ack,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output DATA_ADDR,
        output DATA_OUT,
        output BYTE_ENABLE,
        output WRITE_ENABLE,
        output READ_ENABLE
    );

    modport master (
        output req_valid,
        output req_store,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output DATA_IN,
        output mem_ack,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  DATA_ADDR,
        input  DATA_OUT,
        input  BYTE_ENABLE,
        input  WRITE_ENABLE,
        input  READ_ENABLE
    );
endinterface

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//
// Purpose: load/store unit between the core's execute stage and data RAM.
// Takes one decoded LOAD/STORE at a time, produces the RAM word address, the
// byte-lane enables and the lane-replicated store data, waits for the RAM
// acknowledge (with a timeout), then returns the sign/zero-extended load
// result or an error.
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   bus      lsu_mem_port_if.slave, request/response and RAM signals
//
// Parameters:
//   MAX_WAIT cycles spent in ACCESS without mem_ack before the request is
//            aborted with resp_err (must be >= 1)
//
// Optional feature (compile-time macro LSU_MISALIGN_TRAP_EN):
//   defined   - misaligned half/word accesses complete immediately with
//               resp_err and never touch the RAM
//   undefined - the low address bits are ignored for halves/words, so the
//               access is force-aligned and proceeds normally
//
// All outputs are registered and come straight from the FSM block.
// ---------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int MAX_WAIT = 255
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_port_if.slave bus
);

    // The wait counter counts 0 .. MAX_WAIT-1 while in ACCESS.
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic [CNT_W-1:0] waitCnt_q;

    // Request fields kept for the load extraction at acknowledge time.
    logic [1:0]  addrLo_q;
    logic [2:0]  funct3_q;
    logic        store_q;

    // Registered outputs.
    logic        reqReady_q;
    logic        respValid_q;
    logic [31:0] respRdata_q;
    logic        respErr_q;
    logic [31:0] dataAddr_q;
    logic [31:0] dataOut_q;
    logic [3:0]  byteEnable_q;
    logic        writeEnable_q;
    logic        readEnable_q;

    // Combinational decode of the incoming request.
    logic        reqIllegal_d;
    logic        reqMisaligned_d;
    logic [3:0]  laneMask_d;
    logic [31:0] storeData_d;
    logic [31:0] loadData_d;

    // Legal combinations are the five load widths and the three store
    // widths; the unsigned codes only exist for loads.
    always_comb begin
        reqIllegal_d = 1'b1;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: reqIllegal_d = 1'b0;
            3'b100, 3'b101:         reqIllegal_d = bus.req_store;
            default:                reqIllegal_d = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // A half must sit on an even address, a word on a multiple of four.
    always_comb begin
        reqMisaligned_d = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   reqMisaligned_d = bus.req_addr[0];
            2'b10:   reqMisaligned_d = |bus.req_addr[1:0];
            default: reqMisaligned_d = 1'b0;
        endcase
    end
`else
    // Without the trap the lane and extraction logic simply ignore the
    // offending low bits, so nothing is ever flagged as misaligned.
    assign reqMisaligned_d = 1'b0;
`endif

    // Byte-lane enables and replicated store data. Replication puts the
    // store bytes on every lane so the RAM only needs the enables to pick
    // the right ones. funct3[2] does not matter here because the unsigned
    // codes share their width with the signed ones.
    always_comb begin
        laneMask_d  = 4'b1111;
        storeData_d = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                laneMask_d  = 4'b0001 << bus.req_addr[1:0];
                storeData_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                laneMask_d  = 4'b0011 << {bus.req_addr[1], 1'b0};
                storeData_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                laneMask_d  = 4'b1111;
                storeData_d = bus.req_wdata;
            end
        endcase
    end

    // Pick the addressed byte/half out of the RAM word and extend it
    // according to the latched width code.
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        loadByte = bus.DATA_IN[7:0];
        case (addrLo_q)
            2'd0:    loadByte = bus.DATA_IN[7:0];
            2'd1:    loadByte = bus.DATA_IN[15:8];
            2'd2:    loadByte = bus.DATA_IN[23:16];
            default: loadByte = bus.DATA_IN[31:24];
        endcase
        loadHalf = addrLo_q[1] ? bus.DATA_IN[31:16] : bus.DATA_IN[15:0];
        case (funct3_q)
            3'b000:  loadData_d = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData_d = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData_d = {24'd0, loadByte};
            3'b101:  loadData_d = {16'd0, loadHalf};
            default: loadData_d = bus.DATA_IN;
        endcase
    end

    // Main FSM with registered outputs. Bad requests skip ACCESS and go
    // straight to RESP with the error flag, so the RAM never sees them.
    // In ACCESS an acknowledge is checked before the timeout so an ack on
    // the last allowed cycle still completes successfully. Reset is
    // asynchronous, so an in-flight request is dropped silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            waitCnt_q     <= '0;
            addrLo_q      <= 2'd0;
            funct3_q      <= 3'd0;
            store_q       <= 1'b0;
            reqReady_q    <= 1'b1;
            respValid_q   <= 1'b0;
            respRdata_q   <= 32'd0;
            respErr_q     <= 1'b0;
            dataAddr_q    <= 32'd0;
            dataOut_q     <= 32'd0;
            byteEnable_q  <= 4'd0;
            writeEnable_q <= 1'b0;
            readEnable_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && reqReady_q) begin
                        addrLo_q   <= bus.req_addr[1:0];
                        funct3_q   <= bus.req_funct3;
                        store_q    <= bus.req_store;
                        waitCnt_q  <= '0;
                        reqReady_q <= 1'b0;
                        if (reqIllegal_d || reqMisaligned_d) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            respRdata_q <= 32'd0;
                        end else begin
                            state_q       <= ACCESS;
                            dataAddr_q    <= {bus.req_addr[31:2], 2'b00};
                            dataOut_q     <= storeData_d;
                            byteEnable_q  <= laneMask_d;
                            writeEnable_q <= bus.req_store;
                            readEnable_q  <= ~bus.req_store;
                        end
                    end
                end

                ACCESS: begin
                    if (bus.mem_ack || (waitCnt_q == LAST_CNT)) begin
                        state_q       <= RESP;
                        respValid_q   <= 1'b1;
                        respErr_q     <= ~bus.mem_ack;
                        respRdata_q   <= (bus.mem_ack && !store_q) ? loadData_d : 32'd0;
                        dataAddr_q    <= 32'd0;
                        dataOut_q     <= 32'd0;
                        byteEnable_q  <= 4'd0;
                        writeEnable_q <= 1'b0;
                        readEnable_q  <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end

                RESP: begin
                    state_q     <= IDLE;
                    respValid_q <= 1'b0;
                    respErr_q   <= 1'b0;
                    respRdata_q <= 32'd0;
                    reqReady_q  <= 1'b1;
                end

                default: begin
                    state_q       <= IDLE;
                    reqReady_q    <= 1'b1;
                    respValid_q   <= 1'b0;
                    respErr_q     <= 1'b0;
                    respRdata_q   <= 32'd0;
                    writeEnable_q <= 1'b0;
                    readEnable_q  <= 1'b0;
                    byteEnable_q  <= 4'd0;
                end
            endcase
        end
    end

    assign bus.req_ready    = reqReady_q;
    assign bus.resp_valid   = respValid_q;
    assign bus.resp_rdata   = respRdata_q;
    assign bus.resp_err     = respErr_q;
    assign bus.DATA_ADDR    = dataAddr_q;
    assign bus.DATA_OUT     = dataOut_q;
    assign bus.BYTE_ENABLE  = byteEnable_q;
    assign bus.WRITE_ENABLE = writeEnable_q;
    assign bus.READ_ENABLE  = readEnable_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port
//
// Self-checking bench for lsu_mem_port. The bench plays both the core and a
// small word-wide RAM. Expected results come from a constant vector table
// and, for random traffic, from a byte-array reference of memory that
// applies the load/store rules directly.
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

    localparam int TB_MAX_WAIT = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] ram      [0:255];
    logic [7:0]  refBytes [0:1023];

    lsu_mem_port_if bus();

    lsu_mem_port #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
        bit          expErr;
        bit          expAcc;
        logic [31:0] expRd;
        logic [3:0]  expBe;
        logic [31:0] expDout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int k, input bit err, input bit acc,
                                input logic [31:0] rd, input logic [3:0] be, input logic [31:0] dout);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.k = k;
        v.expErr = err; v.expAcc = acc; v.expRd = rd; v.expBe = be; v.expDout = dout;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: effect of one request on a byte-addressed memory.
    task automatic refCompute(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int k, output vec_t v);
        int size;
        int ai;
        int base;
        bit illegal;
        logic [31:0] val;
        v = mk(st, f3, a, wd, k, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                  || (st && f3 >= 3'd4);
        if (illegal) begin
            v.expErr = 1'b1;
            return;
        end
        size = 1 << f3[1:0];
        ai   = int'(a);
        if (TRAP && (ai % size) != 0) begin
            v.expErr = 1'b1;
            return;
        end
        base = ai - (ai % size);
        v.expAcc = 1'b1;
        for (int i = 0; i < size; i++) v.expBe[(base % 4) + i] = 1'b1;
        for (int j = 0; j < 4; j++) v.expDout[8*j +: 8] = wd[8*(j % size) +: 8];
        if (k > TB_MAX_WAIT) begin
            v.expErr = 1'b1;
            return;
        end
        if (st) begin
            for (int i = 0; i < size; i++) refBytes[base + i] = wd[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val = val | (32'(refBytes[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val - (32'd1 << (8 * size));
            v.expRd = val;
        end
    endtask

    // One full transaction: present request, act as RAM (ack on the k-th
    // ACCESS cycle), then check the response pulse and return to idle.
    task automatic applyStimulus(input vec_t v, input string nm);
        int enCycles;
        bit holdOk;
        logic [31:0] expAddr;
        int idx;
        expAddr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        checkOutput({nm, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = v.st;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.expAcc) begin
            checkOutput({nm, ".addr"}, bus.DATA_ADDR, expAddr);
            checkOutput({nm, ".be"}, 32'(bus.BYTE_ENABLE), 32'(v.expBe));
            checkOutput({nm, ".we"}, 32'(bus.WRITE_ENABLE), 32'(v.st));
            checkOutput({nm, ".re"}, 32'(bus.READ_ENABLE), 32'(!v.st));
            if (v.st) checkOutput({nm, ".dout"}, bus.DATA_OUT, v.expDout);
            enCycles = 0;
            holdOk   = 1'b1;
            for (int c = 1; c <= TB_MAX_WAIT; c++) begin
                if (bus.READ_ENABLE || bus.WRITE_ENABLE) enCycles++;
                if (bus.DATA_ADDR != expAddr || bus.BYTE_ENABLE != v.expBe ||
                    bus.READ_ENABLE != !v.st || bus.WRITE_ENABLE != v.st ||
                    bus.req_ready || bus.resp_valid) holdOk = 1'b0;
                if (v.st && bus.DATA_OUT != v.expDout) holdOk = 1'b0;
                if (c == v.k) begin
                    idx = int'(bus.DATA_ADDR[9:2]);
                    bus.mem_ack = 1'b1;
                    bus.DATA_IN = ram[idx];
                    if (bus.WRITE_ENABLE) begin
                        for (int j = 0; j < 4; j++)
                            if (bus.BYTE_ENABLE[j]) ram[idx][8*j +: 8] = bus.DATA_OUT[8*j +: 8];
                    end
                end else begin
                    bus.req_valid  = 1'($urandom);
                    bus.req_funct3 = 3'($urandom);
                    bus.req_addr   = $urandom;
                    bus.DATA_IN    = $urandom;
                end
                @(negedge clk);
                bus.mem_ack   = 1'b0;
                bus.req_valid = 1'b0;
                bus.DATA_IN   = $urandom;
                if (c == v.k) break;
            end
            checkOutput({nm, ".enCycles"}, 32'(enCycles),
                        32'((v.k <= TB_MAX_WAIT) ? v.k : TB_MAX_WAIT));
            checkOutput({nm, ".hold"}, 32'(holdOk), 32'd1);
        end
        checkOutput({nm, ".respValid"}, 32'(bus.resp_valid), 32'd1);
        checkOutput({nm, ".respErr"}, 32'(bus.resp_err), 32'(v.expErr));
        checkOutput({nm, ".rdata"}, bus.resp_rdata, v.expRd);
        checkOutput({nm, ".enOff"}, 32'(bus.READ_ENABLE | bus.WRITE_ENABLE), 32'd0);
        @(negedge clk);
        checkOutput({nm, ".pulseEnd"}, 32'({bus.resp_valid, bus.req_ready}), 32'b01);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_ack    = 1'b0;
        bus.DATA_IN    = 32'd0;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[64]  = 32'h80FF7F01;
        ram[128] = 32'hDEADBEEF;

        // Reset state
        #12;
        checkOutput("reset.ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset.respValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("reset.enables", 32'({bus.READ_ENABLE, bus.WRITE_ENABLE}), 32'd0);
        checkOutput("reset.be", 32'(bus.BYTE_ENABLE), 32'd0);
        checkOutput("reset.addr", bus.DATA_ADDR, 32'd0);
        checkOutput("reset.rdataErr", {bus.resp_rdata[30:0], bus.resp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // mem_ack while idle must do nothing
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ack = 1'b1;
            bus.DATA_IN = 32'hA5A5A5A5;
            checkOutput("ackIdle.valid", 32'(bus.resp_valid), 32'd0);
            checkOutput("ackIdle.ready", 32'(bus.req_ready), 32'd1);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("ackIdle.final", 32'({bus.resp_valid, bus.READ_ENABLE, bus.req_ready}), 32'b001);

        // Directed vector table
        vecs.push_back(mk(0, 3'b000, 32'h101, 0, 1, 0, 1, 32'h0000007F, 4'b0010, 0));
        vecs.push_back(mk(0, 3'b000, 32'h103, 0, 2, 0, 1, 32'hFFFFFF80, 4'b1000, 0));
        vecs.push_back(mk(0, 3'b100, 32'h103, 0, 1, 0, 1, 32'h00000080, 4'b1000, 0));
        vecs.push_back(mk(0, 3'b001, 32'h102, 0, 3, 0, 1, 32'hFFFF80FF, 4'b1100, 0));
        vecs.push_back(mk(0, 3'b101, 32'h100, 0, 1, 0, 1, 32'h00007F01, 4'b0011, 0));
        vecs.push_back(mk(0, 3'b010, 32'h100, 0, 2, 0, 1, 32'h80FF7F01, 4'b1111, 0));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234ABCD, 1, 0, 1, 0, 4'b1100, 32'hABCDABCD));
        vecs.push_back(mk(0, 3'b010, 32'h100, 0, 1, 0, 1, 32'hABCD7F01, 4'b1111, 0));
        vecs.push_back(mk(1, 3'b000, 32'h101, 32'h00000055, 2, 0, 1, 0, 4'b0010, 32'h55555555));
        if (TRAP) vecs.push_back(mk(0, 3'b010, 32'h201, 0, 1, 1, 0, 0, 4'b0000, 0));
        else      vecs.push_back(mk(0, 3'b010, 32'h201, 0, 1, 0, 1, 32'hDEADBEEF, 4'b1111, 0));
        vecs.push_back(mk(0, 3'b011, 32'h100, 0, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 3'b100, 32'h100, 32'h77, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 3'b110, 32'h100, 0, 1, 1, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 3'b010, 32'h100, 0, 9, 1, 1, 0, 4'b1111, 0));
        vecs.push_back(mk(0, 3'b010, 32'h100, 0, 4, 0, 1, 32'hABCD5501, 4'b1111, 0));
        if (TRAP) vecs.push_back(mk(0, 3'b001, 32'h103, 0, 1, 1, 0, 0, 4'b0000, 0));
        else      vecs.push_back(mk(0, 3'b001, 32'h103, 0, 1, 0, 1, 32'hFFFFABCD, 4'b1100, 0));
        vecs.push_back(mk(1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 0, 1, 0, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b000, 32'h106, 0, 1, 0, 1, 32'hFFFFFFFE, 4'b0100, 0));
        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of ACCESS drops the request without response
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("rstAccess.reBefore", 32'(bus.READ_ENABLE), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstAccess.enables", 32'({bus.READ_ENABLE, bus.WRITE_ENABLE}), 32'd0);
        checkOutput("rstAccess.valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rstAccess.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rstAccess.after", 32'({bus.resp_valid, bus.READ_ENABLE, bus.req_ready}), 32'b001);
        end

        // Random traffic against the byte-level reference
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) refBytes[4*w + b] = ram[w][8*b +: 8];
        for (int n = 0; n < 80; n++) begin
            logic [2:0] f3;
            int r;
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1:    f3 = 3'b000;
                2, 3:    f3 = 3'b001;
                4, 5:    f3 = 3'b010;
                6, 7:    f3 = 3'b100;
                8, 9:    f3 = 3'b101;
                10:      f3 = 3'b011;
                default: f3 = 3'($urandom_range(6, 7));
            endcase
            refCompute(1'($urandom), f3, 32'($urandom_range(0, 1023)), $urandom,
                       int'($urandom_range(1, 6)), v);
            applyStimulus(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
